// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, multiplier, iterative divider, data-SRAM request
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         EXE_signal_valid,
    input  logic [157:0] EXE_signal,
    input  logic         MEM_allowin,
    output logic         EXE_allowin,
    output logic         MEM_signal_valid,
    output logic [70:0]  MEM_signal,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         exe_rf_we,
    output logic [4:0]   exe_rf_waddr,
    output logic         exe_is_load
);

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    logic        exe_valid;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rkd_value;
    logic        res_from_mem;
    logic [3:0]  mem_we;
    logic [18:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;

    logic [1:0]  div_state;
    logic [5:0]  div_count;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [31:0] div_b;
    logic        sign_q;
    logic        sign_r;

    logic        is_div;
    logic        div_signed;
    logic        div_is_mod;
    logic        exe_readygo;
    logic [32:0] div_shifted;
    logic [32:0] div_trial;
    logic [31:0] div_q_final;
    logic [31:0] div_r_final;
    logic [31:0] div_result;
    logic        mul_ext1;
    logic        mul_ext2;
    logic [63:0] mul_prod;
    logic [31:0] result;
    logic        mem_fire;

    assign is_div      = |alu_op[18:15];
    assign div_signed  = alu_op[15] | alu_op[17];
    assign div_is_mod  = alu_op[17] | alu_op[18];
    assign exe_readygo = !is_div || (div_state == DIV_DONE);
    assign EXE_allowin = !exe_valid || (exe_readygo && MEM_allowin);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exe_valid    <= 1'b0;
            pc           <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rkd_value    <= '0;
            res_from_mem <= 1'b0;
            mem_we       <= '0;
            alu_op       <= '0;
            src1         <= '0;
            src2         <= '0;
        end else if (EXE_allowin) begin
            exe_valid <= EXE_signal_valid;
            if (EXE_signal_valid) begin
                {pc, rf_we, rf_waddr, rkd_value, res_from_mem,
                 mem_we, alu_op, src1, src2} <= EXE_signal;
            end
        end
    end

    // Restoring step: the trial difference never exceeds 32 bits when it succeeds,
    // so bit 32 of the 33-bit difference is a clean borrow flag.
    assign div_shifted = {div_rem, div_quo[31]};
    assign div_trial   = div_shifted - {1'b0, div_b};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_state <= DIV_IDLE;
            div_count <= '0;
            div_rem   <= '0;
            div_quo   <= '0;
            div_b     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (exe_valid && is_div) begin
                        div_state <= DIV_RUN;
                        div_count <= '0;
                        div_rem   <= '0;
                        div_quo   <= (div_signed && src1[31]) ? -src1 : src1;
                        div_b     <= (div_signed && src2[31]) ? -src2 : src2;
                        sign_q    <= div_signed && (src1[31] ^ src2[31]);
                        sign_r    <= div_signed && src1[31];
                    end
                end
                DIV_RUN: begin
                    div_rem   <= div_trial[32] ? div_shifted[31:0] : div_trial[31:0];
                    div_quo   <= {div_quo[30:0], ~div_trial[32]};
                    div_count <= div_count + 6'd1;
                    if (div_count == 6'd31) begin
                        div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (MEM_allowin) begin
                        div_state <= DIV_IDLE;
                    end
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        div_q_final = sign_q ? -div_quo : div_quo;
        div_r_final = sign_r ? -div_rem : div_rem;
        if (src2 == 32'd0) begin
            div_q_final = 32'hFFFF_FFFF;
            div_r_final = src1;
        end
        div_result = div_is_mod ? div_r_final : div_q_final;
    end

    assign mul_ext1 = alu_op[13] & src1[31];
    assign mul_ext2 = alu_op[13] & src2[31];
    assign mul_prod = {{32{mul_ext1}}, src1} * {{32{mul_ext2}}, src2};

    always_comb begin
        result = 32'd0;
        if (alu_op[0])       result = src1 + src2;
        else if (alu_op[1])  result = src1 - src2;
        else if (alu_op[2])  result = {31'd0, $signed(src1) < $signed(src2)};
        else if (alu_op[3])  result = {31'd0, src1 < src2};
        else if (alu_op[4])  result = src1 & src2;
        else if (alu_op[5])  result = ~(src1 | src2);
        else if (alu_op[6])  result = src1 | src2;
        else if (alu_op[7])  result = src1 ^ src2;
        else if (alu_op[8])  result = src1 << src2[4:0];
        else if (alu_op[9])  result = src1 >> src2[4:0];
        else if (alu_op[10]) result = $signed(src1) >>> src2[4:0];
        else if (alu_op[11]) result = src2;
        else if (alu_op[12]) result = mul_prod[31:0];
        else if (alu_op[13] || alu_op[14]) result = mul_prod[63:32];
        else if (is_div)     result = div_result;
    end

    assign mem_fire         = exe_valid && MEM_allowin;
    assign MEM_signal_valid = exe_valid && exe_readygo;
    assign MEM_signal       = {pc, rf_we, rf_waddr, res_from_mem, result};
    assign data_sram_en     = mem_fire && (res_from_mem || (mem_we != 4'd0));
    assign data_sram_we     = mem_we & {4{mem_fire}};
    assign data_sram_addr   = result;
    assign data_sram_wdata  = rkd_value;
    assign exe_rf_we        = exe_valid && rf_we;
    assign exe_rf_waddr     = rf_waddr;
    assign exe_is_load      = exe_valid && res_from_mem;

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage LoongArch-subset pipeline, directly downstream of the decode stage. Latches the 158-bit decode bundle under a valid/allowin handshake, computes the ALU, multiply and iterative-divide result, and issues the data-SRAM request. Passes a 71-bit bundle to the memory stage and exports its destination register so decode can detect load-use hazards.

## Interface
Parameters:
- none. Widths are fixed by the bundle formats below.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low: 0 = reset.
- EXE_signal_valid  in  1  decode has a valid instruction on EXE_signal.
- EXE_signal  in  158  bundle fields:
  - pc[157:126]
  - rf_we[125]
  - rf_waddr[124:120]
  - rkd_value[119:88]
  - res_from_mem[87]
  - mem_we[86:83]
  - alu_op[82:64]
  - alu_src1[63:32]
  - alu_src2[31:0]
- MEM_allowin  in  1  memory stage can accept this cycle.
- EXE_allowin  out  1  this stage accepts a new bundle this cycle.
- MEM_signal_valid  out  1  EXE_valid && EXE_readygo.
- MEM_signal  out  71  bundle fields:
  - pc[70:39]
  - rf_we[38]
  - rf_waddr[37:33]
  - res_from_mem[32]
  - result[31:0]
- data_sram_en  out  1  SRAM access strobe.
- data_sram_we  out  4  byte write enables.
- data_sram_addr  out  32  equals result.
- data_sram_wdata  out  32  equals rkd_value.
- exe_rf_we  out  1  EXE_valid && rf_we; for the decode-stage hazard check.
- exe_rf_waddr  out  5  latched rf_waddr.
- exe_is_load  out  1  EXE_valid && res_from_mem.

## Operation
Pipeline register:
- EXE_valid, plus one register per field of the 158-bit bundle.
- EXE_allowin = !EXE_valid || (EXE_readygo && MEM_allowin).
- On a clock edge with EXE_allowin = 1: EXE_valid <= EXE_signal_valid. The payload is loaded only when EXE_signal_valid is also 1.
- EXE_readygo = 1, except for a div/mod op (alu_op[18:15] != 0), where it is 1 only in divider state DONE.

ALU: one-hot alu_op. If no bit is set, result = 0.
- bit 0: add.
- bit 1: sub.
- bit 2: slt (signed) → {31'b0, lt}.
- bit 3: sltu → {31'b0, lt}.
- bit 4: and.
- bit 5: nor.
- bit 6: or.
- bit 7: xor.
- bits 8 / 9 / 10: sll / srl / sra, shift amount src2[4:0].
- bit 11: result = src2 (lu12i).

Multiply: single-cycle combinational 33x33 signed product, with operands sign- or zero-extended per op.
- bit 12: product[31:0].
- bit 13: signed product[63:32].
- bit 14: unsigned product[63:32].

Divide: radix-2 restoring, 32-iteration FSM with states IDLE, RUN, DONE.
- Op mapping: bit 15 = div.w, bit 16 = div.wu, bit 17 = mod.w, bit 18 = mod.wu.
- IDLE → RUN when EXE_valid and a div/mod op are present. Latch |src1| and |src2| (raw values for unsigned ops), sign_q = s1^s2, sign_r = s1. Clear the 6-bit count.
- RUN: each cycle shift {rem, quo} left by 1 and trial-subtract the divisor; on success set the quotient LSB. count++. After count reaches 31, go to DONE.
- DONE: apply signs (quotient negated if sign_q, remainder negated if sign_r).
  - Quotient drives result for div ops; remainder drives it for mod ops.
  - Stay in DONE while MEM_allowin = 0.
  - DONE → IDLE on the edge where MEM_allowin = 1; this is the same edge on which the bundle advances.
- Divide by zero (src2 = 0): in DONE, quotient forced to 0xFFFFFFFF and remainder forced to src1, for all four ops.
- Signed overflow 0x80000000 / 0xFFFFFFFF: div.w result 0x80000000, mod.w result 0. No special case; the algorithm produces these naturally.

Memory request:
- data_sram_en = EXE_valid && MEM_allowin && (res_from_mem || mem_we != 0).
- data_sram_we = mem_we & {4{EXE_valid && MEM_allowin}}.
- Each load or store is therefore issued on exactly one cycle, the cycle it advances.

## Timing
- Reset values:
  - EXE_valid = 0 and all payload registers = 0.
  - Divider in IDLE with count = 0.
  - Consequently MEM_signal_valid, EXE_allowin = 1, data_sram_en = 0, data_sram_we = 0, and exe_* = 0.
- Reset asserted mid-division aborts it: FSM → IDLE and the instruction is dropped.
- Non-divide ops: 1 cycle in the stage; outputs are combinational from the pipeline registers.
- Divide ops:
  - Entry cycle in IDLE, then 32 RUN cycles, then DONE on cycle 33 after entry (EXE_readygo = 1).
  - Minimum occupancy is 34 cycles.
  - EXE_allowin = 0 for the entire occupancy.
- Simultaneous events:
  - Incoming bundle while the stage is stalled by a divide: not latched. Decode holds it, because EXE_allowin = 0.
  - MEM_allowin = 0 during a load/store: no SRAM strobe; the request issues on the later cycle when MEM_allowin = 1.
  - Back-to-back divides: the second divide enters on the edge that leaves DONE and starts in IDLE on the next cycle.

## Test plan
- Add: add with src1 = 0x7FFFFFFF, src2 = 1 → result 0x80000000 and MEM_signal_valid = 1 on the cycle after entry.
- Signed divide: div.w 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD after 34 cycles. mod.w of the same operands → 0xFFFFFFFF. EXE_allowin = 0 throughout.
- Divide by zero and overflow:
  - div.wu 5 / 0 → 0xFFFFFFFF.
  - mod.wu 5 / 0 → 5.
  - div.w 0x80000000 / 0xFFFFFFFF → 0x80000000.
- Multiply high: mulh.w 0xFFFFFFFF × 0xFFFFFFFF → 0; mulh.wu of the same operands → 0xFFFFFFFE, in one cycle.
- Store under back-pressure: store with mem_we = 4'hF, addr 0x1C, while MEM_allowin = 0 for 3 cycles → data_sram_en stays 0. It then pulses exactly once with we = 4'hF, addr 0x1C and wdata = rkd_value.
- Reset during division: reset driven low at RUN count 10 → EXE_valid = 0 and FSM in IDLE. A new addi issued after release completes in 1 cycle.
